// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the stopwatch timekeeping core.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  // Terminal value of each BCD digit position
  localparam bcd_t CS_MAX       = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam bcd_t UNITS_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  // Terminal value for digit position idx (0 = centisecond units .. 5 = minute tens)
  function automatic bcd_t digit_max(input int idx);
    case (idx)
      0, 1:    return CS_MAX;
      3:       return SEC_TENS_MAX;
      5:       return MIN_TENS_MAX;
      default: return UNITS_MAX;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch cascade: counts 0..MAX on inc, wraps to 0,
// and raises carry in the cycle it wraps so the next digit can advance.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = UNITS_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  assign carry = inc && (q == MAX);

  // Digit register: clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == MAX) ? '0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping core: prescales clk to a TICK_HZ tick and keeps an
// MM:SS.cc BCD count with start/stop, clear and lap-hold control.
// Optional feature macro: STOPWATCH_LAP_EN enables the lap snapshot and hold
// mux; without it lap is ignored, held is 0 and digits always show the count.
// Control inputs are single-cycle pulses sampled on the rising edge; there is
// no handshake, a pulse high at edge N takes effect at edge N.
// dbg_state exposes the control FSM state for checkers.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic [23:0] digits,
  output logic        running,
  output logic        held,
  output logic        wrap,
  output sw_state_t   dbg_state
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  sw_state_t     state;
  sw_state_t     state_nx;
  logic [PW-1:0] presc;
  logic          tick;
  logic [5:0]    inc;
  logic [5:0]    carry;
  bcd_t          q [6];
  logic [23:0]   count;
  logic          running_q;
  logic          wrap_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state: clear overrides start_stop
  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_nx = RUN;
        RUN:     state_nx = PAUSE;
        PAUSE:   state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Prescaler advances only while running and keeps sub-tick phase in PAUSE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clear) begin
      presc <= '0;
    end else if (state == RUN) begin
      presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
    end
  end

  assign tick = (state == RUN) && (presc == PRESC_LAST);

  // Carry chain: each digit advances when every lower digit is at terminal
  assign inc[0] = tick;
  for (genvar i = 1; i < 6; i++) begin : g_inc
    assign inc[i] = carry[i-1];
  end

  for (genvar i = 0; i < 6; i++) begin : g_digit
    bcd_digit #(
      .MAX(digit_max(i))
    ) u_digit (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clear),
      .inc  (inc[i]),
      .q    (q[i]),
      .carry(carry[i])
    );
  end

  assign count = {q[5], q[4], q[3], q[2], q[1], q[0]};

  // Registered status flags; wrap marks the 59:59.99 -> 00:00.00 rollover edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      running_q <= (state_nx == RUN);
      wrap_q    <= carry[5] && !clear;
    end
  end

  assign running   = running_q;
  assign wrap      = wrap_q;
  assign dbg_state = state;

`ifdef STOPWATCH_LAP_EN
  logic        held_q;
  logic [23:0] snapshot;

  // Lap hold toggle; entering hold captures the count seen before this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q   <= 1'b0;
      snapshot <= '0;
    end else if (clear) begin
      held_q <= 1'b0;
    end else if (lap) begin
      held_q <= !held_q;
      if (!held_q) begin
        snapshot <= count;
      end
    end
  end

  assign held   = held_q;
  assign digits = held_q ? snapshot : count;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign held       = 1'b0;
  assign digits     = count;
`endif

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter at CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// Expected values are queued when stimulus is applied and popped at each check.
module tb_stopwatch_counter;
  import stopwatch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        lap = 1'b0;
  logic [23:0] digits;
  logic        running;
  logic        held;
  logic        wrap;
  sw_state_t   dbg_state;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [23:0] preload_v;

`ifdef STOPWATCH_LAP_EN
  localparam logic LAP_ON = 1'b1;
`else
  localparam logic LAP_ON = 1'b0;
`endif

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  stopwatch_counter #(
    .CLK_HZ (1000),
    .TICK_HZ(100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .digits    (digits),
    .running   (running),
    .held      (held),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // Driver tasks (called at a falling edge)
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic ss, input logic cl, input logic lp);
    start_stop = ss;
    clear      = cl;
    lap        = lp;
    @(negedge clk);
    start_stop = 1'b0;
    clear      = 1'b0;
    lap        = 1'b0;
  endtask

  // Loads the count digits mid-cycle so long rollovers can be reached quickly
  task preload(input logic [23:0] v);
    preload_v = v;
    force dut.g_digit[0].u_digit.q = preload_v[3:0];
    force dut.g_digit[1].u_digit.q = preload_v[7:4];
    force dut.g_digit[2].u_digit.q = preload_v[11:8];
    force dut.g_digit[3].u_digit.q = preload_v[15:12];
    force dut.g_digit[4].u_digit.q = preload_v[19:16];
    force dut.g_digit[5].u_digit.q = preload_v[23:20];
    #1;
    release dut.g_digit[0].u_digit.q;
    release dut.g_digit[1].u_digit.q;
    release dut.g_digit[2].u_digit.q;
    release dut.g_digit[3].u_digit.q;
    release dut.g_digit[4].u_digit.q;
    release dut.g_digit[5].u_digit.q;
  endtask

  // Scoreboard
  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  initial begin
    // Reset state
    push(32'h0); push(32'h0); push(32'h0); push(32'h0); push({30'h0, IDLE});
    step(2);
    check("rst_digits", {8'h0, digits});
    check("rst_running", {31'h0, running});
    check("rst_held", {31'h0, held});
    check("rst_wrap", {31'h0, wrap});
    check("rst_state", {30'h0, dbg_state});
    rst_n = 1'b1;
    step(1);

    // Start: first increment DIV cycles after the start edge, then 1.00 s
    pulse(1'b1, 1'b0, 1'b0);
    push(32'h1); push({30'h0, RUN});
    check("start_running", {31'h0, running});
    check("start_state", {30'h0, dbg_state});
    push(32'h000000);
    step(9);
    check("pre_first_tick", {8'h0, digits});
    push(32'h000001);
    step(1);
    check("first_tick", {8'h0, digits});
    push(32'h000100); push(32'h1);
    step(990);
    check("one_second", {8'h0, digits});
    check("one_second_running", {31'h0, running});

    // 00:09.99 -> 00:10.00
    push(32'h000999);
    step(8990);
    check("at_9_99", {8'h0, digits});
    push(32'h001000);
    step(10);
    check("carry_to_sec_tens", {8'h0, digits});

    // Pause with prescaler at 4, hold 500 cycles, resume
    step(3);
    pulse(1'b1, 1'b0, 1'b0);
    push(32'h001000); push(32'h0); push({30'h0, PAUSE});
    check("pause_digits", {8'h0, digits});
    check("pause_running", {31'h0, running});
    check("pause_state", {30'h0, dbg_state});
    push(32'h001000);
    step(500);
    check("pause_hold_500", {8'h0, digits});
    pulse(1'b1, 1'b0, 1'b0);
    push(32'h1);
    check("resume_running", {31'h0, running});
    push(32'h001000);
    step(5);
    check("resume_before_tick", {8'h0, digits});
    push(32'h001001);
    step(1);
    check("resume_tick_6", {8'h0, digits});

    // 00:59.99 -> 01:00.00
    preload(24'h005999);
    push(32'h005999);
    step(9);
    check("at_59_99", {8'h0, digits});
    push(32'h010000);
    step(1);
    check("carry_to_min", {8'h0, digits});

    // 59:59.99 -> 00:00.00 with a one-cycle wrap pulse
    preload(24'h595999);
    push(32'h595999); push(32'h0);
    step(9);
    check("at_max", {8'h0, digits});
    check("wrap_before", {31'h0, wrap});
    push(32'h000000); push(32'h1); push(32'h1);
    step(1);
    check("wrap_digits", {8'h0, digits});
    check("wrap_pulse", {31'h0, wrap});
    check("wrap_running", {31'h0, running});
    push(32'h0); push(32'h000000);
    step(1);
    check("wrap_one_cycle", {31'h0, wrap});
    check("after_wrap_digits", {8'h0, digits});

    // Lap hold at 00:05.12 while counting continues underneath
    preload(24'h000512);
    pulse(1'b0, 1'b0, 1'b1);
    push({31'h0, LAP_ON}); push(32'h000512);
    check("lap_held", {31'h0, held});
    check("lap_digits", {8'h0, digits});
    push(LAP_ON ? 32'h000512 : 32'h000542); push({31'h0, LAP_ON});
    step(300);
    check("lap_300_digits", {8'h0, digits});
    check("lap_300_held", {31'h0, held});
    pulse(1'b0, 1'b0, 1'b1);
    push(32'h000542); push(32'h0);
    check("unlap_digits", {8'h0, digits});
    check("unlap_held", {31'h0, held});

    // clear + start_stop + lap together while running
    pulse(1'b1, 1'b1, 1'b1);
    push(32'h0); push(32'h0); push(32'h0); push({30'h0, IDLE}); push(32'h0);
    check("clr_digits", {8'h0, digits});
    check("clr_running", {31'h0, running});
    check("clr_held", {31'h0, held});
    check("clr_state", {30'h0, dbg_state});
    check("clr_wrap", {31'h0, wrap});
    pulse(1'b1, 1'b0, 1'b0);
    push(32'h000000);
    step(9);
    check("clr_presc_zero", {8'h0, digits});
    push(32'h000001);
    step(1);
    check("clr_first_tick", {8'h0, digits});

    // Asynchronous reset mid-count, checked before the next rising edge
    step(5);
    #2;
    rst_n = 1'b0;
    #1;
    push(32'h0); push(32'h0); push({30'h0, IDLE});
    check("async_rst_digits", {8'h0, digits});
    check("async_rst_running", {31'h0, running});
    check("async_rst_state", {30'h0, dbg_state});
    step(2);
    rst_n = 1'b1;
    step(1);

    // Final report
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timekeeping core of the stopwatch: divides the board clock down to a 100 Hz tick and maintains an MM:SS.cc BCD count with start/stop, clear and lap-hold control. Its 24-bit digit bus feeds six downstream hex-to-seven-segment decoders, one nibble per display. Control inputs come from the already-debounced, edge-detected key logic as single-cycle pulses.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 100: count rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_stop  in  1  single-cycle pulse; toggles run/pause.
- clear  in  1  single-cycle pulse; zeroes count and stops.
- lap  in  1  single-cycle pulse; toggles display hold.
- digits  out  24  BCD display value:
  - [3:0] centisecond units; [7:4] centisecond tens.
  - [11:8] second units; [15:12] second tens.
  - [19:16] minute units; [23:20] minute tens.
- running  out  1  high while counting.
- held  out  1  high while the display shows the lap snapshot.
- wrap  out  1  one-cycle pulse when the count rolls over from 59:59.99 to 00:00.00.

## Operation
- Reset (asynchronous): count = 0, prescaler = 0, snapshot = 0, running = 0, held = 0, wrap = 0, digits = 0.
- States:
  - IDLE: stopped, count zero.
  - RUN: counting.
  - PAUSE: stopped, count nonzero.
- Transitions:
  - IDLE→RUN on start_stop.
  - RUN→PAUSE on start_stop.
  - PAUSE→RUN on start_stop.
  - Any state→IDLE on clear.
  - running = (state == RUN).
- Prescaler:
  - Counts 0..DIV-1, only in RUN.
  - Holds its value in PAUSE, so sub-tick time is preserved across pause/resume.
  - Zeroed by clear.
  - Its width is the ceiling of log2(DIV).
  - tick = RUN && prescaler == DIV-1; the prescaler returns to 0 on that edge.
- BCD cascade on tick:
  - cs units 0-9 → cs tens 0-9 → s units 0-9 → s tens 0-5 → m units 0-9 → m tens 0-5.
  - Each digit increments when all lower digits are at terminal. A digit at terminal with carry-in returns to 0.
  - At 59:59.99 a tick produces 00:00.00, pulses wrap, and the block stays in RUN.
- Lap hold:
  - lap toggles held in any state.
  - On the 0→1 transition, snapshot captures the count value present before that edge.
  - digits = held ? snapshot : count.
  - Counting continues underneath a held display.
- Priority when pulses coincide in one cycle:
  - clear over everything: start_stop and lap are ignored, held is forced to 0.
  - start_stop and lap together: both take effect.
  - lap together with a tick: the snapshot takes the pre-increment value.

## Timing
- digits, running, held and wrap are registered state; a 2:1 hold mux is the only logic between the registers and digits.
- An input pulse at edge N is visible at the outputs after edge N.
- First increment after IDLE→RUN at edge N occurs at edge N+DIV.
- wrap is high for exactly the one cycle following the rollover edge.
- Assertion of rst_n mid-count clears everything immediately, without waiting for a clock edge.

## Configuration
- STOPWATCH_LAP_EN defined: lap input, snapshot register and hold mux are present as described.
- STOPWATCH_LAP_EN undefined:
  - lap is ignored.
  - held is tied to 0.
  - digits = count.
  - No snapshot register is synthesised.

## Structure
- Package stopwatch_pkg holds:
  - typedef bcd_t (4-bit).
  - Digit terminal constants CS_MAX = 9, SEC_TENS_MAX = 5, MIN_TENS_MAX = 5, UNITS_MAX = 9.
  - State enum sw_state_t {IDLE, RUN, PAUSE}.
- Sub-module bcd_digit is instantiated six times:
  - Parameter MAX.
  - Inputs clk, rst_n, clr, inc.
  - Outputs q (bcd_t) and carry; carry = inc && q == MAX.
- The FSM, prescaler and lap logic stay in the top level.

## Test plan
All scenarios use CLK_HZ = 1000, TICK_HZ = 100, so DIV = 10.
- Reset → digits = 0x000000, running = 0, held = 0. Pulse start_stop and run 1000 cycles → digits = 0x000100 (1.00 s), running = 1.
- Counting from 00:09.99, one more tick → 0x001000. From 00:59.99 → 0x010000. From 59:59.99 → 0x000000, wrap pulses for 1 cycle, running stays 1.
- Pause at prescaler = 4, wait 500 cycles, resume → digits unchanged during the pause; next increment arrives 6 cycles after resume.
- Running at 0x000512, pulse lap, wait 300 cycles → digits hold 0x000512 and held = 1. Pulse lap again → digits show the live value 0x000542.
- clear, start_stop and lap pulsed in the same cycle while running → digits = 0, running = 0, held = 0, prescaler = 0.
- Build without STOPWATCH_LAP_EN, pulse lap while running → held stays 0 and digits keep tracking the live count.
